// File: rtl/vec_lane_collector.sv
// Vector ALU write-back collector: merges per-lane result chunks into one VLEN-bit register.
// Define VEC_COLLECT_CHECK_EN to build the sticky protocol-error checker behind `err`.
module vec_lane_collector #(
  parameter int         VLEN       = 128,
  parameter logic [2:0] LANE_WIDTH = 3'b100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      vsew,
  input  logic [3:0]      lane_en,
  input  logic [3:0]      lane_valid,
  input  logic [63:0]     lane_vd0,
  input  logic [63:0]     lane_vd1,
  input  logic [63:0]     lane_vd2,
  input  logic [63:0]     lane_vd3,
  input  logic [9:0]      lane_regi0,
  input  logic [9:0]      lane_regi1,
  input  logic [9:0]      lane_regi2,
  input  logic [9:0]      lane_regi3,
  input  logic [3:0]      lane_done,
  output logic            busy,
  // vd moves to the consumer on any rising edge where out_valid and out_ready are
  // both high; out_valid then holds with vd frozen until that edge (or reset).
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] vd,
  output logic            err,
  output logic [1:0]      state_dbg
);

  localparam int NB            = VLEN / 8;
  localparam int LANE_BITS_RAW = 1 << LANE_WIDTH;
  localparam int LANE_BITS     = (LANE_BITS_RAW > 64) ? 64 : LANE_BITS_RAW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t          state_q;
  logic [VLEN-1:0] vd_q, vd_d;
  logic [NB-1:0]   mask_q, mask_d;
  logic [3:0]      done_q, done_d;
  logic [3:0]      en_q;
  logic [1:0]      sew_q;
  logic            busy_q;
  logic            out_valid_q;
  logic            complete;

  logic [63:0]     lane_vd   [4];
  logic [9:0]      lane_regi [4];
  int              cw;
  logic [63:0]     chunk_mask;
  logic [VLEN-1:0] bit_m;
  logic [NB-1:0]   byte_m;
  logic [3:0]      fits;

`ifdef VEC_COLLECT_CHECK_EN
  logic            chk;
`endif

  // Lane writes are folded in lane order, so a later lane overrides an earlier one.
  always_comb begin
    lane_vd[0]   = lane_vd0;
    lane_vd[1]   = lane_vd1;
    lane_vd[2]   = lane_vd2;
    lane_vd[3]   = lane_vd3;
    lane_regi[0] = lane_regi0;
    lane_regi[1] = lane_regi1;
    lane_regi[2] = lane_regi2;
    lane_regi[3] = lane_regi3;

    cw = 8 << sew_q;
    if (cw > LANE_BITS) cw = LANE_BITS;
    chunk_mask = (cw >= 64) ? '1 : ((64'd1 << cw) - 64'd1);

    vd_d   = vd_q;
    mask_d = mask_q;
    done_d = done_q | lane_done;
    bit_m  = '0;
    byte_m = '0;
    fits   = '0;
`ifdef VEC_COLLECT_CHECK_EN
    chk    = 1'b0;
`endif

    for (int i = 0; i < 4; i++) begin
      fits[i] = (int'(lane_regi[i]) + cw) <= VLEN;
      if (lane_valid[i] && en_q[i] && fits[i]) begin
        bit_m = VLEN'(chunk_mask) << lane_regi[i];
        vd_d  = (vd_d & ~bit_m) | (VLEN'(lane_vd[i] & chunk_mask) << lane_regi[i]);
        for (int b = 0; b < NB; b++) begin
          byte_m[b] = |bit_m[b*8 +: 8];
        end
`ifdef VEC_COLLECT_CHECK_EN
        if (|(byte_m & mask_d)) chk = 1'b1;
`endif
        mask_d = mask_d | byte_m;
      end
`ifdef VEC_COLLECT_CHECK_EN
      if (lane_valid[i]) begin
        if (!en_q[i] || done_q[i]) chk = 1'b1;
        if (en_q[i] && (!fits[i] || ((int'(lane_regi[i]) & (cw - 1)) != 0))) chk = 1'b1;
      end
`endif
    end

    complete = (&mask_d) && ((done_d & en_q) == en_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vd_q        <= '0;
      mask_q      <= '0;
      done_q      <= '0;
      en_q        <= '0;
      sew_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !vsew[2]) begin
            state_q <= S_COLLECT;
            vd_q    <= '0;
            mask_q  <= '0;
            done_q  <= '0;
            en_q    <= lane_en;
            sew_q   <= vsew[1:0];
            busy_q  <= 1'b1;
          end
        end
        S_COLLECT: begin
          vd_q   <= vd_d;
          mask_q <= mask_d;
          done_q <= done_d;
          if (complete) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef VEC_COLLECT_CHECK_EN
  logic err_q;

  // A rejected start (bad vsew) raises err; an accepted one restarts it from the lane_en==0 check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      err_q <= vsew[2] ? 1'b1 : (lane_en == 4'd0);
    end else if (state_q == S_COLLECT) begin
      err_q <= err_q | chk;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign vd        = vd_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vec_lane_collector.sv
// Bench for vec_lane_collector: directed scenarios plus randomized collections, checked by a
// chunk-level reference model feeding an expected queue that a handshake monitor drains.
module tb_vec_lane_collector;

  localparam int VLEN = 128;
  localparam int NB   = VLEN / 8;
  localparam int W    = VLEN + 1;
`ifdef VEC_COLLECT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      vsew;
  logic [3:0]      lane_en;
  logic [3:0]      lane_valid;
  logic [63:0]     lane_vd0, lane_vd1, lane_vd2, lane_vd3;
  logic [9:0]      lane_regi0, lane_regi1, lane_regi2, lane_regi3;
  logic [3:0]      lane_done;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] vd;
  logic            err;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  vec_lane_collector #(.VLEN(VLEN), .LANE_WIDTH(3'b100)) dut (
    .clk(clk), .reset(reset), .start(start), .vsew(vsew), .lane_en(lane_en),
    .lane_valid(lane_valid),
    .lane_vd0(lane_vd0), .lane_vd1(lane_vd1), .lane_vd2(lane_vd2), .lane_vd3(lane_vd3),
    .lane_regi0(lane_regi0), .lane_regi1(lane_regi1), .lane_regi2(lane_regi2), .lane_regi3(lane_regi3),
    .lane_done(lane_done), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .vd(vd), .err(err), .state_dbg(state_dbg)
  );

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkv(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: destination register as a bit array, byte coverage, sticky done
  logic [VLEN-1:0] m_vd;
  logic [NB-1:0]   m_cov;
  logic [3:0]      m_dn, m_en;
  logic            m_err;
  int              m_cw;
  logic [VLEN-1:0] last_exp_vd;

  logic [63:0] tv [4];
  logic [9:0]  tr [4];
  logic [3:0]  tvld, tdn;

  task automatic model_start(input int sew, input logic [3:0] en);
    m_cw  = 8 << sew;
    if (m_cw > 16) m_cw = 16;
    m_vd  = '0;
    m_cov = '0;
    m_dn  = '0;
    m_en  = en;
    m_err = (en == 4'd0);
  endtask

  task automatic model_cycle(output bit complete);
    int base;
    for (int i = 0; i < 4; i++) begin
      if (tvld[i]) begin
        base = int'(tr[i]);
        if (!m_en[i]) begin
          m_err = 1'b1;
        end else begin
          if (m_dn[i]) m_err = 1'b1;
          if (base + m_cw > VLEN) begin
            m_err = 1'b1;
          end else begin
            for (int b = 0; b < m_cw; b++) m_vd[base + b] = tv[i][b];
            for (int by = base / 8; by < (base + m_cw) / 8; by++) begin
              if (m_cov[by]) m_err = 1'b1;
              m_cov[by] = 1'b1;
            end
          end
        end
      end
    end
    m_dn = m_dn | tdn;
    complete = (&m_cov) && ((m_dn & m_en) == m_en);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 4; i++) begin
      tv[i] = '0;
      tr[i] = '0;
    end
    tvld = '0;
    tdn  = '0;
  endtask

  task automatic do_start(input int sew, input logic [3:0] en);
    vsew    = 3'(sew);
    lane_en = en;
    start   = 1'b1;
    model_start(sew, en);
    tick();
    start   = 1'b0;
    lane_en = 4'($urandom_range(0, 15));
    check1("start_busy", busy, 1'b1);
    check1("start_out_valid", out_valid, 1'b0);
    checkv("start_vd_clear", vd, '0);
    check1("start_err", err, CHECK_EN && (en == 4'd0));
  endtask

  task automatic step(input bit use_const, input logic [VLEN-1:0] cvd, output bit c);
    lane_valid = tvld;
    lane_done  = tdn;
    lane_vd0 = tv[0]; lane_vd1 = tv[1]; lane_vd2 = tv[2]; lane_vd3 = tv[3];
    lane_regi0 = tr[0]; lane_regi1 = tr[1]; lane_regi2 = tr[2]; lane_regi3 = tr[3];
    model_cycle(c);
    if (c) begin
      last_exp_vd = use_const ? cvd : m_vd;
      exp_q.push_back({CHECK_EN & m_err, last_exp_vd});
    end
    tick();
    lane_valid = '0;
    lane_done  = '0;
    check1("out_valid_timing", out_valid, c);
  endtask

  task automatic finish_out(input int stall);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        start      = 1'b1;
        vsew       = 3'd0;
        lane_en    = 4'hF;
        lane_valid = 4'hF;
        lane_vd0   = {$urandom, $urandom};
        lane_regi0 = '0;
        tick();
        checkv("stall_vd", vd, last_exp_vd);
        check1("stall_valid", out_valid, 1'b1);
        check1("stall_busy", busy, 1'b1);
      end
      start      = 1'b0;
      lane_valid = '0;
      out_ready  = 1'b1;
      tick();
      out_ready  = 1'b0;
    end else begin
      tick();
    end
    check1("handshake_valid_drop", out_valid, 1'b0);
    check1("handshake_busy_drop", busy, 1'b0);
  endtask

  task automatic run_random();
    int  slots[$];
    int  nslots, sew, r, j, tmp, cyc, stall;
    bit  c;
    logic [3:0] en;
    sew = $urandom_range(0, 3);
    en  = 4'($urandom_range(1, 15));
    stall = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
    out_ready = (stall == 0);
    do_start(sew, en);
    nslots = VLEN / m_cw;
    slots.delete();
    for (int s = 0; s < nslots; s++) slots.push_back(s);
    for (int k = nslots - 1; k > 0; k--) begin
      j = $urandom_range(0, k);
      tmp = slots[k]; slots[k] = slots[j]; slots[j] = tmp;
    end
    c = 1'b0;
    cyc = 0;
    while (!c && cyc < 400) begin
      clear_stim();
      for (int i = 0; i < 4; i++) begin
        tv[i] = {$urandom, $urandom};
        r = $urandom_range(0, 9);
        if (r < 6 && en[i] && slots.size() > 0) begin
          tvld[i] = 1'b1;
          tr[i]   = 10'(slots.pop_front() * m_cw);
        end else if (r == 6) begin
          tvld[i] = 1'b1;
          tr[i]   = 10'($urandom_range(0, nslots - 1) * m_cw);
        end else if (r == 7 && en[i]) begin
          tvld[i] = 1'b1;
          tr[i]   = 10'(VLEN + $urandom_range(0, (1024 - VLEN) / m_cw - 1) * m_cw);
        end
        if (en[i] && (slots.size() == 0 || $urandom_range(0, 7) == 0)) tdn[i] = 1'b1;
      end
      step(1'b0, '0, c);
      cyc++;
    end
    check1("random_completes", c, 1'b1);
    if (c) finish_out(stall);
  endtask

  // scoreboard monitor: pops one expectation per accepted output
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h with nothing expected at %0t", {err, vd}, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({err, vd} !== mon_exp) begin
          errors++;
          $display("FAIL output_err_vd: got %h expected %h at %0t", {err, vd}, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    bit c;
    reset = 1'b1; start = 1'b0; vsew = '0; lane_en = '0; lane_valid = '0; lane_done = '0;
    lane_vd0 = '0; lane_vd1 = '0; lane_vd2 = '0; lane_vd3 = '0;
    lane_regi0 = '0; lane_regi1 = '0; lane_regi2 = '0; lane_regi3 = '0;
    out_ready = 1'b1;
    clear_stim();
    repeat (2) @(posedge clk);
    #1;
    checkv("reset_vd", vd, '0);
    check1("reset_out_valid", out_valid, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // byte lanes, four cycles, done with the last beat
    out_ready = 1'b1;
    do_start(0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      clear_stim();
      for (int i = 0; i < 4; i++) begin
        tvld[i] = 1'b1;
        tr[i]   = 10'((4 * k + i) * 8);
        tv[i]   = 64'(4 * k + i);
      end
      if (k == 3) tdn = 4'hF;
      step(1'b1, 128'h0f0e0d0c0b0a09080706050403020100, c);
    end
    finish_out(0);

    // 32-bit elements capped to 16-bit chunks, two lanes, consumer stalled
    do_start(2, 4'h3);
    for (int k = 0; k < 4; k++) begin
      clear_stim();
      for (int i = 0; i < 2; i++) begin
        tvld[i] = 1'b1;
        tr[i]   = 10'((2 * k + i) * 16);
        tv[i]   = 64'(16'hA000 + 2 * k + i);
      end
      if (k == 3) tdn = 4'h3;
      out_ready = 1'b0;
      step(1'b1, 128'hA007A006A005A004A003A002A001A000, c);
    end
    finish_out(5);

    // all done seen with one slot missing
    out_ready = 1'b1;
    do_start(1, 4'hF);
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      tvld[i] = 1'b1; tr[i] = 10'(i * 16); tv[i] = 64'(16'hC000 + i);
    end
    step(1'b0, '0, c);
    clear_stim();
    for (int i = 0; i < 3; i++) begin
      tvld[i] = 1'b1; tr[i] = 10'((4 + i) * 16); tv[i] = 64'(16'hC004 + i);
    end
    tdn = 4'hF;
    step(1'b0, '0, c);
    clear_stim();
    step(1'b0, '0, c);
    step(1'b0, '0, c);
    tvld[3] = 1'b1; tr[3] = 10'(7 * 16); tv[3] = 64'h0000_0000_0000_C007;
    step(1'b1, 128'hC007C006C005C004C003C002C001C000, c);
    finish_out(0);

    // asynchronous reset in the middle of a collection
    do_start(0, 4'hF);
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      tvld[i] = 1'b1; tr[i] = 10'(i * 8); tv[i] = 64'hFF;
    end
    step(1'b0, '0, c);
    #3;
    reset = 1'b1;
    #1;
    checkv("async_reset_vd", vd, '0);
    check1("async_reset_busy", busy, 1'b0);
    check1("async_reset_out_valid", out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    do_start(0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      clear_stim();
      for (int i = 0; i < 4; i++) begin
        tvld[i] = 1'b1; tr[i] = 10'((4 * k + i) * 8); tv[i] = 64'(8'h30 + 4 * k + i);
      end
      if (k == 3) tdn = 4'hF;
      step(1'b1, 128'h3f3e3d3c3b3a39383736353433323130, c);
    end
    finish_out(0);

    // lanes 0 and 1 collide on regi 0: lane 1 wins
    do_start(1, 4'hF);
    clear_stim();
    tvld = 4'hF;
    tr[0] = 10'd0;  tv[0] = 64'h2222_3333_4444_1111;
    tr[1] = 10'd0;  tv[1] = 64'h5555_6666_7777_2222;
    tr[2] = 10'd16; tv[2] = 64'hB001;
    tr[3] = 10'd32; tv[3] = 64'hB002;
    step(1'b0, '0, c);
    check1("overlap_err", err, CHECK_EN);
    clear_stim();
    for (int i = 0; i < 4; i++) begin
      tvld[i] = 1'b1; tr[i] = 10'((3 + i) * 16); tv[i] = 64'(16'hB003 + i);
    end
    step(1'b0, '0, c);
    clear_stim();
    tvld[0] = 1'b1; tr[0] = 10'(7 * 16); tv[0] = 64'hB007; tdn = 4'hF;
    step(1'b1, 128'hB007B006B005B004B003B002B0012222, c);
    checkv("overlap_vd", vd, 128'hB007B006B005B004B003B002B0012222);
    finish_out(0);

    // illegal vsew is rejected
    vsew = 3'd5; lane_en = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    check1("bad_vsew_busy", busy, 1'b0);
    check1("bad_vsew_err", err, CHECK_EN);

    // no lane enabled: collection can never finish
    do_start(0, 4'h0);
    clear_stim();
    tvld = 4'hF; tdn = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tr[i] = 10'(i * 8); tv[i] = 64'hAA;
    end
    for (int k = 0; k < 3; k++) step(1'b0, '0, c);
    check1("no_lane_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();

    for (int t = 0; t < 40; t++) run_random();

    repeat (3) tick();
    checkv("queue_drained", VLEN'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_lane_collector.md
# vec_lane_collector

Write-back collector for the vector ALU lanes. It receives the per-lane result chunks (`vd`, `regi`, `done`) that the `vec_alu` lanes emit each cycle and assembles them into one full VLEN-bit destination register. It presents that register to the vector register file over a valid/ready handshake. It sits between the lane array (`vec_alu_wrapper` outputs) and the register-file write port.

## Interface
Parameters:
- `VLEN`, 128 — vector register width in bits; multiple of 64.
- `LANE_WIDTH`, 3'b100 — log2 of lane datapath width (16 bits by default).

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — begin a new collection; accepted only in IDLE.
- `vsew`  in  3  — element width code (0..3 → 8/16/32/64 bits), sampled on accepted `start`.
- `lane_en`  in  4  — active-lane mask, sampled on accepted `start`.
- `lane_valid`  in  4  — lane *i* presents a chunk this cycle.
- `lane_vd0`..`lane_vd3`  in  64 each  — lane chunk data, LSB-aligned.
- `lane_regi0`..`lane_regi3`  in  10 each  — bit offset of the chunk in the destination.
- `lane_done`  in  4  — lane *i* has finished (sticky once seen).
- `busy`  out  1  — high in COLLECT and OUT.
- `out_valid`  out  1  — `vd` is complete.
- `out_ready`  in  1  — consumer accepts `vd`.
- `vd`  out  VLEN  — assembled destination register.
- `err`  out  1  — sticky protocol error flag; cleared by an accepted `start`.

## Operation
- Chunk width: CW = min(8 << vsew, 1 << LANE_WIDTH). Slot count: VLEN/CW.
- Coverage mask: one bit per byte, VLEN/8 bits total.
- States and transitions:
  - IDLE → COLLECT on `start` with vsew ≤ 3. This clears `vd`, the coverage mask, sticky `done`, and `err`, and latches `vsew` and `lane_en`.
  - In IDLE, `start` with vsew > 3 sets `err` and stays in IDLE.
  - COLLECT: for each *i* with `lane_valid[i]` & `lane_en[i]`, write `lane_vd_i[CW-1:0]` into `vd[regi_i +: CW]` and set the covered mask bytes.
  - Writes within one cycle are applied in lane order 0→3, so the higher lane wins on overlap.
  - A chunk with regi+CW > VLEN is dropped.
  - COLLECT → OUT when the mask is all ones and sticky `done` covers `lane_en`. The state update includes the current cycle's writes and `done`.
  - OUT → IDLE on `out_valid` & `out_ready`.
- In OUT, `vd` is frozen; `lane_valid` and `start` are ignored.
- `lane_en` = 0 with `start`: enter COLLECT and wait until lane chunks cover the mask (done requirement vacuous). No lane is enabled, so this never completes; it is a software error and `err` is set.

## Timing
- Reset values: `vd` = 0, `out_valid` = 0, `busy` = 0, `err` = 0, state IDLE, mask and sticky `done` cleared.
- Reset is asynchronous and takes effect immediately, including mid-COLLECT or in OUT. Partial data is discarded.
- `start` accepted at edge *t*: `busy` = 1 after *t*. Lane inputs at edge *t* itself are ignored; capture starts at *t*+1.
- Final chunk or `done` captured at edge *t*: `out_valid` = 1 after *t*. Latency from last lane write to `out_valid` is 1 cycle.
- Handshake at edge *t* (`out_valid` & `out_ready`): `out_valid` = 0 and `busy` = 0 after *t*. A new `start` is accepted at *t*+1 at the earliest.
- `out_ready` may be held high permanently, giving a 1-cycle OUT. `out_valid` never drops without a handshake or reset.
- All `done` seen but mask incomplete: remain in COLLECT. The same applies to a full mask with `done` missing.

## Configuration
- `VEC_COLLECT_CHECK_EN` defined: `err` is set when any of the following occurs:
  - a chunk overwrites already-covered bytes;
  - regi is not a multiple of CW;
  - regi is out of range;
  - `lane_valid` is asserted on a lane not in `lane_en`;
  - `lane_valid` is asserted on a lane whose sticky `done` is already set;
  - vsew > 3 on `start`;
  - `start` is given with `lane_en` = 0.
- `VEC_COLLECT_CHECK_EN` undefined: `err` is tied to 0 and no check logic is built. Out-of-range chunks are still dropped, and overlaps still resolve higher-lane-wins. The vsew > 3 `start` is still rejected, silently.

## Test plan
- VLEN=128, LANE_WIDTH=4, vsew=0, `lane_en`=4'hF. Drive 4 cycles; lane *i* in cycle *k* sends regi=(4k+i)*8 with byte value 4k+i, and all `done` assert in cycle 3. Required: `out_valid` one cycle later with `vd` = 128'h0f0e0d0c0b0a09080706050403020100 and `err`=0.
- vsew=2 (CW capped to 16), `lane_en`=4'h3. Drive 4 cycles; lane *i* in cycle *k* sends regi=(2k+i)*16 with data 16'hA000+2k+i. Required: `vd` = 128'hA007A006A005A004A003A002A001A000.
- Hold `out_ready`=0 for 5 cycles after completion, pulsing `start` and `lane_valid` meanwhile. Required: `vd` and `out_valid` stable and `busy`=1; after `out_ready`=1, `out_valid` drops on the next edge.
- Assert all `done` with one slot missing. Required: no `out_valid` until that chunk arrives, then `out_valid` 1 cycle later.
- Assert `reset` mid-COLLECT. Required: `vd`=0, `busy`=0, `out_valid`=0 immediately. The next `start` collects a fresh vector correctly.
- With `VEC_COLLECT_CHECK_EN`: lanes 0 and 1 write the same regi=0 in one cycle. Required: `err`=1 and `vd[15:0]` = lane 1 data. Without the macro: `err`=0 with the same `vd`.
